// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bundle.
//   imem_req   fetch request, held until imem_valid
//   imem_addr  word-aligned fetch address, stable while imem_req=1
//   imem_rdata instruction word, meaningful when imem_valid=1
//   imem_valid response for the outstanding request (may be zero-wait)
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
//   clk, reset       clock; synchronous active-high reset
//   imem             request/response handshake to instruction memory (master)
//   StallD, FlushD   hazard controls: hold IF/ID / load a bubble into IF/ID
//   PCSrcW, ResultW  fetch redirect from writeback (target forced word-aligned)
//   InstrD, PCPlus8D decode-stage instruction and its fetch address + 8
//   ValidD           InstrD is a real instruction (0 for bubbles)
//   Op/Funct/Rd/Cond instruction fields sliced from InstrD
// A one-entry skid buffer catches a response that arrives while IF/ID cannot
// take it, so variable-latency memory never loses or repeats a word.
module fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    imem,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD,
    output logic [1:0]       Op,
    output logic [5:0]       Funct,
    output logic [3:0]       Rd,
    output logic [3:0]       Cond
);

    // Cond=NV so the controller never executes a bubble.
    localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(32'hF000_0000);

    typedef enum logic [1:0] {StIdle, StFetch, StHeld, StDiscard} state_e;

    state_e           state, nextState;
    logic [WIDTH-1:0] PCF, reqAddr;
    logic [WIDTH-1:0] heldInstr, heldAddr;
    logic             heldValid;

    logic             reqOut, outstanding;
    logic             acceptD, acceptHeld, releaseHeld, discardDone;
    logic [WIDTH-1:0] target;

    assign reqOut      = (state == StFetch) || (state == StDiscard);
    // A request still waiting for its response after this cycle.
    assign outstanding = reqOut && !imem.imem_valid;
    assign target      = ResultW & ~WIDTH'(3);

    // Redirect overrides every other action in the cycle.
    assign acceptD     = !PCSrcW && (state == StFetch) && imem.imem_valid && !StallD && !FlushD;
    assign acceptHeld  = !PCSrcW && (state == StFetch) && imem.imem_valid && (StallD || FlushD);
    assign releaseHeld = !PCSrcW && (state == StHeld) && heldValid && !StallD && !FlushD;
    assign discardDone = !PCSrcW && (state == StDiscard) && imem.imem_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= StIdle;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle:    nextState = StFetch;
            StFetch:   if (imem.imem_valid) nextState = (StallD || FlushD) ? StHeld : StFetch;
            StHeld:    if (releaseHeld) nextState = StFetch;
            StDiscard: if (imem.imem_valid) nextState = StFetch;
            default:   nextState = StIdle;
        endcase
        if (PCSrcW) nextState = outstanding ? StDiscard : StFetch;
    end

    // Outputs
    always_comb begin
        imem.imem_req  = reqOut;
        imem.imem_addr = reqAddr;
        Op             = InstrD[27:26];
        Funct          = InstrD[25:20];
        Rd             = InstrD[15:12];
        Cond           = InstrD[31:28];
    end

    // Fetch PC, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            PCF       <= RESET_PC;
            reqAddr   <= RESET_PC;
            heldValid <= 1'b0;
            heldInstr <= BUBBLE;
            heldAddr  <= '0;
            InstrD    <= BUBBLE;
            PCPlus8D  <= '0;
            ValidD    <= 1'b0;
        end else begin
            if (PCSrcW) begin
                PCF <= target;
                // Keep the stale address on the bus until its response drains.
                if (!outstanding) reqAddr <= target;
            end else if (acceptD || acceptHeld) begin
                PCF     <= PCF + WIDTH'(4);
                reqAddr <= PCF + WIDTH'(4);
            end else if (discardDone) begin
                reqAddr <= PCF;
            end

            if (PCSrcW) begin
                heldValid <= 1'b0;
            end else if (acceptHeld) begin
                heldValid <= 1'b1;
                heldInstr <= imem.imem_rdata;
                heldAddr  <= reqAddr;
            end else if (releaseHeld) begin
                heldValid <= 1'b0;
            end

            if (PCSrcW || FlushD) begin
                InstrD   <= BUBBLE;
                PCPlus8D <= '0;
                ValidD   <= 1'b0;
            end else if (acceptD) begin
                InstrD   <= imem.imem_rdata;
                PCPlus8D <= reqAddr + WIDTH'(8);
                ValidD   <= 1'b1;
            end else if (releaseHeld) begin
                InstrD   <= heldInstr;
                PCPlus8D <= heldAddr + WIDTH'(8);
                ValidD   <= 1'b1;
            end else if (!StallD) begin
                InstrD   <= BUBBLE;
                PCPlus8D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized stall/flush/redirect/reset
// traffic against a variable-latency memory, checked every cycle against a
// transaction-level model (pending request, queue of held words, decode slot).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallD = 1'b0, FlushD = 1'b0, PCSrcW = 1'b0;
    logic [31:0] ResultW = '0;
    logic [31:0] InstrD, PCPlus8D;
    logic        ValidD;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd, Cond;

    fetch_stage_if #(.WIDTH(32)) imem ();

    fetch_stage #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCSrcW   (PCSrcW),
        .ResultW  (ResultW),
        .InstrD   (InstrD),
        .PCPlus8D (PCPlus8D),
        .ValidD   (ValidD),
        .Op       (Op),
        .Funct    (Funct),
        .Rd       (Rd),
        .Cond     (Cond)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // Memory responder state; waitCfg < 0 picks a random latency per request.
    bit memBusy = 0;
    int memWait = 0;
    int waitCfg = 0;

    // Reference model
    bit          checkEn = 0;
    bit          mActive = 0;
    bit          mDrop = 0;
    logic [31:0] mReqA = RST_PC, mPc = RST_PC;
    logic [31:0] mInstr = BUBBLE, mPc8 = '0;
    bit          mValid = 0;
    logic [63:0] heldQ[$];

    task automatic modelStep(input bit rst, input bit st, input bit fl, input bit pc,
                             input logic [31:0] res, input bit v, input logic [31:0] d);
        bit          req, resp, gotWord;
        logic [63:0] w;
        gotWord = 0;
        w = '0;
        if (rst) begin
            mActive = 0; mDrop = 0; heldQ.delete();
            mReqA = RST_PC; mPc = RST_PC;
            mInstr = BUBBLE; mPc8 = '0; mValid = 0;
        end else begin
            req  = mActive && (heldQ.size() == 0);
            resp = req && v;
            if (pc) begin
                mPc = res & 32'hFFFF_FFFC;
                heldQ.delete();
                if (req && !v) mDrop = 1;
                else begin mDrop = 0; mReqA = mPc; end
                mInstr = BUBBLE; mPc8 = '0; mValid = 0;
            end else begin
                if (resp && mDrop) begin
                    mDrop = 0; mReqA = mPc;
                end else if (resp) begin
                    w = {d, mReqA};
                    mReqA = mReqA + 32'd4;
                    mPc = mReqA;
                    if (st || fl) heldQ.push_back(w);
                    else gotWord = 1;
                end
                if (fl) begin
                    mInstr = BUBBLE; mPc8 = '0; mValid = 0;
                end else if (gotWord) begin
                    mInstr = w[63:32]; mPc8 = w[31:0] + 32'd8; mValid = 1;
                end else if (!st) begin
                    if (heldQ.size() != 0) begin
                        w = heldQ.pop_front();
                        mInstr = w[63:32]; mPc8 = w[31:0] + 32'd8; mValid = 1;
                    end else begin
                        mInstr = BUBBLE; mPc8 = '0; mValid = 0;
                    end
                end
            end
            mActive = 1;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            automatic bit expReq = mActive && (heldQ.size() == 0);
            chk("imem_req", 32'(imem.imem_req), 32'(expReq));
            if (expReq) chk("imem_addr", imem.imem_addr, mReqA);
            chk("ValidD", 32'(ValidD), 32'(mValid));
            chk("InstrD", InstrD, mInstr);
            if (mValid) chk("PCPlus8D", PCPlus8D, mPc8);
            chk("Op", 32'(Op), 32'(mInstr[27:26]));
            chk("Funct", 32'(Funct), 32'(mInstr[25:20]));
            chk("Rd", 32'(Rd), 32'(mInstr[15:12]));
            chk("Cond", 32'(Cond), 32'(mInstr[31:28]));
        end
    end

    // One clock of stimulus: memory reacts to the registered request, inputs are
    // driven at negedge, the model advances at posedge, caller samples at +1.
    task automatic step(input bit rst, input bit st, input bit fl, input bit pc,
                        input logic [31:0] res, input bit forceValid);
        bit          v;
        logic [31:0] d;
        @(negedge clk);
        v = 0;
        d = $urandom;
        if (forceValid) begin
            v = 1; d = 32'h1234_5678; memBusy = 0;
        end else if (rst) begin
            memBusy = 0;
        end else if (imem.imem_req) begin
            if (!memBusy) begin
                memBusy = 1;
                memWait = (waitCfg < 0) ? int'($urandom_range(0, 3)) : waitCfg;
            end
            if (memWait == 0) begin
                v = 1; d = memWord(imem.imem_addr); memBusy = 0;
            end else begin
                memWait--;
            end
        end else begin
            memBusy = 0;
        end
        reset = rst; StallD = st; FlushD = fl; PCSrcW = pc; ResultW = res;
        imem.imem_valid = v; imem.imem_rdata = d;
        @(posedge clk);
        modelStep(rst, st, fl, pc, res, v, d);
        #1;
    endtask

    initial begin
        int k;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = '0;

        step(1, 0, 0, 0, 0, 0);
        checkEn = 1;
        step(1, 0, 0, 0, 0, 0);
        chk("reset imem_req", 32'(imem.imem_req), 0);
        chk("reset imem_addr", imem.imem_addr, RST_PC);
        chk("reset InstrD", InstrD, 32'hF000_0000);
        chk("reset PCPlus8D", PCPlus8D, 0);
        chk("reset ValidD", 32'(ValidD), 0);
        chk("reset Cond", 32'(Cond), 32'hF);
        chk("reset Op/Funct/Rd", {24'(Op), Funct, 2'(Rd)} | 32'(Rd), 0);

        // Zero-wait sequential fetch
        waitCfg = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("first req", 32'(imem.imem_req), 1);
        chk("first addr", imem.imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("seq InstrD0", InstrD, 32'hE000_0000);
        chk("seq PCPlus8D0", PCPlus8D, 32'h8);
        chk("seq ValidD0", 32'(ValidD), 1);
        chk("seq addr4", imem.imem_addr, 32'h4);
        step(0, 0, 0, 0, 0, 0);
        chk("seq addr8", imem.imem_addr, 32'h8);
        chk("seq InstrD4", InstrD, 32'hE000_0004);

        // Stall with skid: word for 0x8 returns while stalled
        step(0, 1, 0, 0, 0, 0);
        chk("skid req off", 32'(imem.imem_req), 0);
        chk("skid hold", InstrD, 32'hE000_0004);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("skid hold3", InstrD, 32'hE000_0004);
        step(0, 0, 0, 0, 0, 0);
        chk("skid release", InstrD, 32'hE000_0008);
        chk("skid next addr", imem.imem_addr, 32'hC);
        chk("skid next req", 32'(imem.imem_req), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("skid after", InstrD, 32'hE000_000C);

        // Redirect during outstanding request with 2 wait states
        waitCfg = 2;
        step(0, 0, 0, 0, 0, 0);
        chk("redir pending addr", imem.imem_addr, 32'h10);
        step(0, 0, 0, 1, 32'h103, 0);
        chk("redir stale addr", imem.imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);
        chk("redir target addr", imem.imem_addr, 32'h100);
        chk("redir dropped", 32'(ValidD), 0);
        k = 0;
        while (!ValidD && k < 6) begin
            step(0, 0, 0, 0, 0, 0);
            k++;
        end
        chk("redir arrival", 32'(ValidD), 1);
        chk("redir InstrD", InstrD, 32'hE000_0100);
        chk("redir PCPlus8D", PCPlus8D, 32'h108);

        // Flush coincident with a response
        waitCfg = 0;
        step(0, 0, 1, 0, 0, 0);
        chk("flush bubble", InstrD, 32'hF000_0000);
        chk("flush ValidD", 32'(ValidD), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush kept word", InstrD, 32'hE000_0104);
        chk("flush next addr", imem.imem_addr, 32'h108);
        step(0, 0, 0, 0, 0, 0);
        chk("flush continues", InstrD, 32'hE000_0108);

        // Address wrap
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("wrap target", imem.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap PCPlus8D", PCPlus8D, 32'h4);
        chk("wrap addr", imem.imem_addr, 32'h0);

        // Reset mid-wait, then a late response
        waitCfg = 2;
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rstwait req", 32'(imem.imem_req), 0);
        chk("rstwait ValidD", 32'(ValidD), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("late ignored", 32'(ValidD), 0);
        chk("restart addr", imem.imem_addr, RST_PC);
        chk("restart req", 32'(imem.imem_req), 1);
        waitCfg = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("restart InstrD", InstrD, 32'hE000_0000);

        // Randomized traffic
        waitCfg = -1;
        for (int i = 0; i < 4000; i++) begin
            automatic bit          r  = ($urandom_range(0, 99) < 1);
            automatic bit          s  = ($urandom_range(0, 99) < 25);
            automatic bit          f  = ($urandom_range(0, 99) < 10);
            automatic bit          p  = ($urandom_range(0, 99) < 6);
            automatic logic [31:0] t  = ($urandom_range(0, 3) == 0) ?
                                        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(r, s, f, p, t, 0);
        end
        step(0, 0, 0, 0, 0, 0);

        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
